seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Iterative shift-add unsigned multiplier. It is the inverse-operation companion to the datapath's iterative divider and uses the same Load/Done handshake style.
- The controller issues Load with operands (normally ACC_reg and MDR_reg) and waits for Done.
- The result is presented as high and low halves, so the controller can write either half to ACC.
- Fixed latency, one multiplier bit retired per cycle.

Parameters:
- WIDTH, 16, operand width; product is 2*WIDTH bits split into P_hi/P_lo.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  multiplicand; sampled only on an accepted Load.
- B  input  WIDTH  multiplier; sampled only on an accepted Load.
- Load  input  1  start request; level sampled at posedge.
- P_hi  output  WIDTH  upper half of product; registered.
- P_lo  output  WIDTH  lower half of product; registered.
- Ovf  output  1  registered; 1 when P_hi != 0, i.e. product does not fit in ACC.
- Busy  output  1  registered; 1 while iterating.
- Done  output  1  registered; one-cycle completion pulse.

Behaviour:
- Reset: rst=1 at a posedge forces state=IDLE. P_hi=0, P_lo=0, Ovf=0, Busy=0, Done=0, and all internal working registers and the counter are 0. Reset takes priority over Load and aborts any calculation in progress with no Done pulse.
- States: IDLE, CALC. Done is a registered pulse, not a separate state.
- IDLE, Load=1 at edge k:
  - mcand<=A, work_hi<=0, work_lo<=B, cnt<=0, Busy<=1, state<=CALC.
  - P_hi/P_lo/Ovf hold their previous result.
- CALC, each edge:
  - sum = {1'b0,work_hi} + (work_lo[0] ? mcand : 0), WIDTH+1 bits.
  - {work_hi,work_lo} <= {sum,work_lo[WIDTH-1:1]}, i.e. a right shift of the carry, sum and low bits.
  - cnt<=cnt+1.
- Completion: the edge with cnt==WIDTH-1 (edge k+WIDTH) performs the final iteration and also:
  - loads P_hi/P_lo with the final values;
  - sets Ovf=|final_hi;
  - Busy<=0, Done<=1, state<=IDLE.
- Latency: Load accepted at edge k; Done high during the cycle following edge k+WIDTH (k+16 by default), for exactly one cycle. The latency is independent of operand values; there is no early exit on zero.
- Done clears at the next edge unconditionally.
- Back-to-back: a Load sampled during the Done cycle is accepted at that edge. Done still falls and Busy rises on the same edge.
- Load while Busy=1 is ignored. Operand changes during CALC have no effect.
- Outputs are stable from Done until the completion of the next accepted operation.
- Width rule: the product is exact modulo 2^(2*WIDTH), with no truncation. The carry out of the adder is never lost because it shifts into work_hi[WIDTH-1].
- cnt width is clog2(WIDTH); it does not wrap during normal operation because it is reset on every accept.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=1'b0, ST_CALC=1'b1;
  - the default WIDTH=16, shared with the divider and datapath;
  - the counter-width function.
- One natural sub-module: mul_addc, a WIDTH-bit adder with carry-out producing sum[WIDTH:0]. It is instantiated once, combinationally, in CALC.
- The FSM, counter and shift registers stay in seq_multiplier.

Test Plan:
- Reset, then A=3, B=5, Load pulsed 1 cycle → Busy high 16 cycles; Done pulses once 16 cycles after the accept edge; P_hi=0x0000, P_lo=0x000F, Ovf=0.
- A=0xFFFF, B=0xFFFF → P_hi=0xFFFE, P_lo=0x0001, Ovf=1, same 16-cycle latency.
- A=0x1234, B=0 and A=0, B=0xBEEF → P=0 and Ovf=0, with Done still at exactly cycle 16 (no early exit).
- Load A=0x0100, B=0x0100, then pulse Load with A=7, B=7 at cycle 5 → second Load ignored; result P_hi=0x0001, P_lo=0x0000, Ovf=1; no second Done.
- Start A=0x00FF, B=0x0002, assert rst at cycle 8 → all outputs 0 and no Done. A fresh Load of 0x00FF*0x0002 gives P_lo=0x01FE.
- Back-to-back: Load held high continuously with A=2, B=3 then A=4, B=5 → Done pulses at cycle 16 and cycle 33 after the first accept, with P_lo=0x0006 then 0x0014. P_lo holds 0x0006 throughout the second calculation.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the iterative multiply/divide datapath.
// Holds state encoding, the default operand width and the counter-width helper.
package seq_multiplier_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_e;

    // Iteration counter width; at least one bit so WIDTH=1 still elaborates.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_multiplier_mul_addc.sv
// WIDTH-bit adder with carry-out for the shift-add multiplier step.
module mul_addc #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_sum
);

    assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// Load/Done handshake; product exposed as registered high and low halves.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Load,
    output logic [WIDTH-1:0] P_hi,
    output logic [WIDTH-1:0] P_lo,
    output logic             Ovf,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0] r_work_hi, w_work_hi_nxt;
    logic [WIDTH-1:0] r_work_lo, w_work_lo_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_p_hi, w_p_hi_nxt;
    logic [WIDTH-1:0] r_p_lo, w_p_lo_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_shift_hi;
    logic [WIDTH-1:0] w_shift_lo;

    assign w_addend = r_work_lo[0] ? r_mcand : '0;

    mul_addc #(
        .WIDTH (WIDTH)
    ) u_addc (
        .i_a   (r_work_hi),
        .i_b   (w_addend),
        .o_sum (w_sum)
    );

    // Carry lands in work_hi MSB; sum LSB shifts into work_lo MSB.
    assign w_shift_hi = w_sum[WIDTH:1];
    assign w_shift_lo = {w_sum[0], r_work_lo[WIDTH-1:1]};

    always_comb begin
        w_state_nxt   = r_state;
        w_mcand_nxt   = r_mcand;
        w_work_hi_nxt = r_work_hi;
        w_work_lo_nxt = r_work_lo;
        w_cnt_nxt     = r_cnt;
        w_p_hi_nxt    = r_p_hi;
        w_p_lo_nxt    = r_p_lo;
        w_ovf_nxt     = r_ovf;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (Load) begin
                    w_mcand_nxt   = A;
                    w_work_hi_nxt = '0;
                    w_work_lo_nxt = B;
                    w_cnt_nxt     = '0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = ST_CALC;
                end
            end
            ST_CALC: begin
                w_work_hi_nxt = w_shift_hi;
                w_work_lo_nxt = w_shift_lo;
                w_cnt_nxt     = r_cnt + 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_p_hi_nxt  = w_shift_hi;
                    w_p_lo_nxt  = w_shift_lo;
                    w_ovf_nxt   = |w_shift_hi;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_mcand   <= '0;
            r_work_hi <= '0;
            r_work_lo <= '0;
            r_cnt     <= '0;
            r_p_hi    <= '0;
            r_p_lo    <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mcand   <= w_mcand_nxt;
            r_work_hi <= w_work_hi_nxt;
            r_work_lo <= w_work_lo_nxt;
            r_cnt     <= w_cnt_nxt;
            r_p_hi    <= w_p_hi_nxt;
            r_p_lo    <= w_p_lo_nxt;
            r_ovf     <= w_ovf_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign P_hi = r_p_hi;
    assign P_lo = r_p_lo;
    assign Ovf  = r_ovf;
    assign Busy = r_busy;
    assign Done = r_done;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: table of products plus
// hand-written sequences for ignored Load, reset abort and back-to-back.
module tb_seq_multiplier;

    localparam int unsigned W = 16;
    localparam int LIMIT = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] a, b;
    logic [W-1:0] p_hi, p_lo;
    logic         ovf, busy, done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    seq_multiplier #(
        .WIDTH (W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (a),
        .B    (b),
        .Load (load),
        .P_hi (p_hi),
        .P_lo (p_lo),
        .Ovf  (ovf),
        .Busy (busy),
        .Done (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input vec_t v);
        int n;
        int busy_cycles;
        a    = v.a;
        b    = v.b;
        load = 1'b1;
        tick();
        load = 1'b0;
        busy_cycles = 0;
        for (n = 1; n <= LIMIT; n++) begin
            if (busy) busy_cycles++;
            tick();
            if (done) break;
        end
        check({name, " latency"}, n, 16);
        check({name, " busy_cycles"}, busy_cycles, 16);
        check({name, " p_hi"}, {16'h0, p_hi}, {16'h0, v.hi});
        check({name, " p_lo"}, {16'h0, p_lo}, {16'h0, v.lo});
        check({name, " ovf"}, {31'h0, ovf}, {31'h0, v.ovf});
        check({name, " busy_at_done"}, {31'h0, busy}, 32'h0);
        tick();
        check({name, " done_one_cycle"}, {31'h0, done}, 32'h0);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    initial begin
        int n;
        int m;
        int dones;
        int hold_err;

        vecs[0] = '{a: 16'h0003, b: 16'h0005, hi: 16'h0000, lo: 16'h000F, ovf: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, hi: 16'hFFFE, lo: 16'h0001, ovf: 1'b1};
        vecs[2] = '{a: 16'h1234, b: 16'h0000, hi: 16'h0000, lo: 16'h0000, ovf: 1'b0};
        vecs[3] = '{a: 16'h0000, b: 16'hBEEF, hi: 16'h0000, lo: 16'h0000, ovf: 1'b0};
        vecs[4] = '{a: 16'hABCD, b: 16'h1234, hi: 16'h0C37, lo: 16'h4FA4, ovf: 1'b1};
        vecs[5] = '{a: 16'h8000, b: 16'h0002, hi: 16'h0001, lo: 16'h0000, ovf: 1'b1};
        vecs[6] = '{a: 16'h00FF, b: 16'h0002, hi: 16'h0000, lo: 16'h01FE, ovf: 1'b0};

        rst  = 1'b1;
        load = 1'b0;
        a    = '0;
        b    = '0;
        tick();
        tick();
        check("reset p_hi", {16'h0, p_hi}, 32'h0);
        check("reset p_lo", {16'h0, p_lo}, 32'h0);
        check("reset ovf", {31'h0, ovf}, 32'h0);
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Second Load mid-calculation must be ignored.
        a    = 16'h0100;
        b    = 16'h0100;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (n = 1; n <= LIMIT; n++) begin
            if (n == 5) begin
                a    = 16'h0007;
                b    = 16'h0007;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
            if (done) break;
        end
        load = 1'b0;
        check("ignload latency", n, 16);
        check("ignload p_hi", {16'h0, p_hi}, 32'h0001);
        check("ignload p_lo", {16'h0, p_lo}, 32'h0000);
        check("ignload ovf", {31'h0, ovf}, 32'h1);
        count_dones(20, dones);
        check("ignload extra_done", dones, 0);

        // Reset mid-calculation aborts with no Done and clears the result.
        a    = 16'h00FF;
        b    = 16'h0002;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort p_hi", {16'h0, p_hi}, 32'h0);
        check("abort p_lo", {16'h0, p_lo}, 32'h0);
        check("abort ovf", {31'h0, ovf}, 32'h0);
        check("abort busy", {31'h0, busy}, 32'h0);
        check("abort done", {31'h0, done}, 32'h0);
        count_dones(20, dones);
        check("abort no_done", dones, 0);
        run_op("after_abort", vecs[6]);

        // Back-to-back with Load held high.
        a    = 16'h0002;
        b    = 16'h0003;
        load = 1'b1;
        tick();
        a = 16'h0004;
        b = 16'h0005;
        for (n = 1; n <= LIMIT; n++) begin
            tick();
            if (done) break;
        end
        check("b2b first latency", n, 16);
        check("b2b first p_lo", {16'h0, p_lo}, 32'h0006);
        tick();
        load = 1'b0;
        check("b2b done_fall", {31'h0, done}, 32'h0);
        check("b2b busy_rise", {31'h0, busy}, 32'h1);
        hold_err = 0;
        for (m = 1; m <= LIMIT; m++) begin
            if (p_lo !== 16'h0006) hold_err++;
            tick();
            if (done) break;
        end
        check("b2b p_lo hold", hold_err, 0);
        check("b2b second latency", n + 1 + m, 33);
        check("b2b second p_lo", {16'h0, p_lo}, 32'h0014);
        check("b2b second p_hi", {16'h0, p_hi}, 32'h0000);
        check("b2b second ovf", {31'h0, ovf}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
